// File: rtl/intra_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : intra_pkg
//  Description : Shared types and constants for the luma 16x16 intra stages.
//  Revision    : 1.0 - initial release
// ============================================================================
package intra_pkg;

    // Pixels in one 16x16 macroblock
    localparam int MB_PIXELS = 256;

    // Mid-grey value used whenever a neighbour set is missing
    localparam logic [7:0] DC_DEFAULT = 8'd128;

    // Mode indices shared with the downstream saver
    typedef enum logic [1:0] {
        MODE_V  = 2'd0,
        MODE_H  = 2'd1,
        MODE_DC = 2'd2
    } mode_t;

    // SAD stage sequencing
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DCP   = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } sad_state_t;

endpackage
`default_nettype wire

// File: rtl/intra16_dc_pred.sv
`default_nettype none
// ============================================================================
//  Module      : intra16_dc_pred
//  Description : Combinational DC predictor from the top/left neighbours.
//  Revision    : 1.0 - initial release
// ============================================================================
module intra16_dc_pred
    import intra_pkg::*;
(
    input  logic [15:0][7:0] top,
    input  logic [15:0][7:0] left,
    input  logic             top_avail,
    input  logic             left_avail,
    output logic [7:0]       dc_pred
);

    logic [12:0] sum_top;
    logic [12:0] sum_left;

    // Neighbour sums and rounded mean, chosen by which neighbours exist
    always_comb begin
        sum_top  = '0;
        sum_left = '0;
        for (int i = 0; i < 16; i++) begin
            sum_top  = sum_top  + 13'(top[i]);
            sum_left = sum_left + 13'(left[i]);
        end
        case ({top_avail, left_avail})
            2'b11:   dc_pred = 8'((sum_top + sum_left + 13'd16) >> 5);
            2'b10:   dc_pred = 8'((sum_top + 13'd8) >> 4);
            2'b01:   dc_pred = 8'((sum_left + 13'd8) >> 4);
            default: dc_pred = DC_DEFAULT;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/sad_luma16x16.sv
`default_nettype none
// ============================================================================
//  Module      : sad_luma16x16
//  Description : Per-mode SAD accumulation and residue generation for the
//                V / H / DC luma 16x16 intra predictions.
//  Revision    : 1.0 - initial release
// ============================================================================
module sad_luma16x16
    import intra_pkg::*;
#(
    parameter int MB_SIZE_L = 16,
    parameter int MB_SIZE_W = 16,
    parameter int SAD_BITS  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [15:0][7:0]          top,
    input  logic [15:0][7:0]          left,
    input  logic                      top_avail,
    input  logic                      left_avail,
    input  logic [12:0]               mbnumber_in,
    input  logic [7:0]                pix,
    input  logic                      pix_valid,
    output logic                      pix_ready,
    output logic                      busy,
    output logic                      done,
    output logic [2:0][SAD_BITS-1:0]  sads,
    output logic [MB_PIXELS-1:0][7:0] vres,
    output logic [MB_PIXELS-1:0][7:0] hres,
    output logic [MB_PIXELS-1:0][7:0] dcres,
    output logic [12:0]               mbnumber
);

    localparam logic [7:0]  C_LAST_K  = 8'(MB_SIZE_L * MB_SIZE_W - 1);
    localparam logic [16:0] C_SAT_MAX = 17'((1 << SAD_BITS) - 1);

    sad_state_t                state_q, state_d;
    logic [15:0][7:0]          top_q, left_q;
    logic                      top_av_q, left_av_q;
    logic [12:0]               mbnumber_q;
    logic [7:0]                dc_q;
    logic [7:0]                k_q;
    logic [2:0][16:0]          acc_q, acc_d;
    logic [2:0][SAD_BITS-1:0]  sads_q, sads_d;
    logic                      done_q;
    logic [MB_PIXELS-1:0][7:0] vres_q, hres_q, dcres_q;

    logic [7:0]                w_dc_pred;
    logic                      w_beat;
    logic [3:0]                w_row, w_col;
    logic [2:0][7:0]           w_pred;
    logic [2:0][8:0]           w_diff;
    logic [2:0][8:0]           w_absd;

    intra16_dc_pred u_dc_pred (
        .top        (top_q),
        .left       (left_q),
        .top_avail  (top_av_q),
        .left_avail (left_av_q),
        .dc_pred    (w_dc_pred)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and handshake outputs; start is only looked at in IDLE
    always_comb begin
        state_d   = state_q;
        pix_ready = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) state_d = DCP;
            end
            DCP:   state_d = ACCUM;
            ACCUM: begin
                pix_ready = 1'b1;
                if (pix_valid && (k_q == C_LAST_K)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign w_beat = pix_valid & pix_ready;
    assign w_row  = k_q[7:4];
    assign w_col  = k_q[3:0];

    // Predictions, signed differences and absolute differences for this pixel
    always_comb begin
        w_pred[MODE_V]  = top_av_q  ? top_q[w_col]  : DC_DEFAULT;
        w_pred[MODE_H]  = left_av_q ? left_q[w_row] : DC_DEFAULT;
        w_pred[MODE_DC] = dc_q;
        for (int m = 0; m < 3; m++) begin
            w_diff[m] = {1'b0, pix} - {1'b0, w_pred[m]};
            w_absd[m] = w_diff[m][8] ? (9'd0 - w_diff[m]) : w_diff[m];
            acc_d[m]  = acc_q[m] + {8'd0, w_absd[m]};
        end
    end

    // Saturated SADs; a missing neighbour set pins its mode to all-ones
    always_comb begin
        for (int m = 0; m < 3; m++) begin
            sads_d[m] = (acc_d[m] > C_SAT_MAX) ? {SAD_BITS{1'b1}} : acc_d[m][SAD_BITS-1:0];
        end
        if (!top_av_q)  sads_d[MODE_V] = '1;
        if (!left_av_q) sads_d[MODE_H] = '1;
    end

    // Neighbour latch, DC capture, beat counter, accumulators and done pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            top_q      <= '0;
            left_q     <= '0;
            top_av_q   <= 1'b0;
            left_av_q  <= 1'b0;
            mbnumber_q <= '0;
            dc_q       <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            sads_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if ((state_q == IDLE) && start) begin
                top_q      <= top;
                left_q     <= left;
                top_av_q   <= top_avail;
                left_av_q  <= left_avail;
                mbnumber_q <= mbnumber_in;
            end
            if (state_q == DCP) begin
                dc_q  <= w_dc_pred;
                k_q   <= '0;
                acc_q <= '0;
            end
            if (w_beat) begin
                k_q   <= k_q + 8'd1;
                acc_q <= acc_d;
                if (k_q == C_LAST_K) begin
                    sads_q <= sads_d;
                    done_q <= 1'b1;
                end
            end
        end
    end

    // Residue arrays, written in raster order as beats arrive (8-bit wrap)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vres_q  <= '0;
            hres_q  <= '0;
            dcres_q <= '0;
        end else if (w_beat) begin
            vres_q[k_q]  <= w_diff[MODE_V][7:0];
            hres_q[k_q]  <= w_diff[MODE_H][7:0];
            dcres_q[k_q] <= w_diff[MODE_DC][7:0];
        end
    end

    assign done     = done_q;
    assign sads     = sads_q;
    assign vres     = vres_q;
    assign hres     = hres_q;
    assign dcres    = dcres_q;
    assign mbnumber = mbnumber_q;

endmodule
`default_nettype wire

// File: tb/tb_sad_luma16x16.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sad_luma16x16
//  Description : Scoreboard testbench for sad_luma16x16 with a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sad_luma16x16;
    import intra_pkg::*;

    typedef logic [255:0][7:0] mb_t;
    typedef logic [15:0][7:0]  nb_t;

    typedef struct packed {
        logic [12:0]     mbn;
        logic [2:0][7:0] sads;
        mb_t             vr;
        mb_t             hr;
        mb_t             dr;
        logic [63:0]     done_t;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    nb_t         tb_top = '0;
    nb_t         tb_left = '0;
    logic        tb_ta = 1'b0;
    logic        tb_la = 1'b0;
    logic [12:0] mbn_in = '0;
    logic [7:0]  pix = '0;
    logic        pix_valid = 1'b0;
    logic        pix_ready, busy, done;
    logic [2:0][7:0] sads;
    mb_t         vres, hres, dcres;
    logic [12:0] mbnumber;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic done_prev = 1'b0;

    sad_luma16x16 #(.MB_SIZE_L(16), .MB_SIZE_W(16), .SAD_BITS(8)) dut (
        .clk(clk), .reset(rst_n), .start(start), .top(tb_top), .left(tb_left),
        .top_avail(tb_ta), .left_avail(tb_la), .mbnumber_in(mbn_in),
        .pix(pix), .pix_valid(pix_valid), .pix_ready(pix_ready), .busy(busy),
        .done(done), .sads(sads), .vres(vres), .hres(hres), .dcres(dcres),
        .mbnumber(mbnumber)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic check_arr(input string name, input mb_t act, input mb_t expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            for (int i = 0; i < 256; i++) begin
                if (act[i] !== expv[i]) begin
                    $display("FAIL %s: index %0d got %0h expected %0h", name, i, act[i], expv[i]);
                    break;
                end
            end
        end
    endtask

    // Reference model straight from the mode definitions
    function automatic exp_t model(input nb_t t, input nb_t l, input logic ta, input logic la,
                                   input mb_t p, input logic [12:0] mbn);
        exp_t e;
        int st, sl, dc, dv, dh, dd, sv, sh, sd, pv, ph;
        e = '0;
        e.mbn = mbn;
        st = 0; sl = 0;
        for (int i = 0; i < 16; i++) begin
            st += int'(t[i]);
            sl += int'(l[i]);
        end
        if (ta && la)  dc = (st + sl + 16) / 32;
        else if (ta)   dc = (st + 8) / 16;
        else if (la)   dc = (sl + 8) / 16;
        else           dc = 128;
        sv = 0; sh = 0; sd = 0;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                pv = ta ? int'(t[c]) : 128;
                ph = la ? int'(l[r]) : 128;
                dv = int'(p[r*16+c]) - pv;
                dh = int'(p[r*16+c]) - ph;
                dd = int'(p[r*16+c]) - dc;
                sv += (dv < 0) ? -dv : dv;
                sh += (dh < 0) ? -dh : dh;
                sd += (dd < 0) ? -dd : dd;
                e.vr[r*16+c] = 8'(dv);
                e.hr[r*16+c] = 8'(dh);
                e.dr[r*16+c] = 8'(dd);
            end
        end
        e.sads[0] = ta ? 8'((sv > 255) ? 255 : sv) : 8'hFF;
        e.sads[1] = la ? 8'((sh > 255) ? 255 : sh) : 8'hFF;
        e.sads[2] = 8'((sd > 255) ? 255 : sd);
        return e;
    endfunction

    // Pixels built on one prediction basis plus sparse noise: 0=top col, 1=left row, 2=flat
    function automatic mb_t make_pix(input nb_t t, input nb_t l, input int basis, input int flat,
                                     input int noise_n);
        mb_t p;
        int v, idx;
        for (int i = 0; i < 256; i++) begin
            if (basis == 0)      p[i] = t[i % 16];
            else if (basis == 1) p[i] = l[i / 16];
            else                 p[i] = 8'(flat);
        end
        for (int n = 0; n < noise_n; n++) begin
            idx = int'($urandom_range(0, 255));
            v = int'(p[idx]) + int'($urandom_range(0, 12)) - 6;
            if (v < 0) v = 0;
            if (v > 255) v = 255;
            p[idx] = 8'(v);
        end
        return p;
    endfunction

    function automatic nb_t rand_nb();
        nb_t n;
        for (int i = 0; i < 16; i++) n[i] = 8'($urandom_range(0, 255));
        return n;
    endfunction

    task automatic check_reset(input string tag);
        check({tag, " done"},      64'(done),      64'd0);
        check({tag, " busy"},      64'(busy),      64'd0);
        check({tag, " pix_ready"}, 64'(pix_ready), 64'd0);
        check({tag, " sads"},      64'(sads),      64'd0);
        check({tag, " mbnumber"},  64'(mbnumber),  64'd0);
        check_arr({tag, " vres"},  vres,  '0);
        check_arr({tag, " hres"},  hres,  '0);
        check_arr({tag, " dcres"}, dcres, '0);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        @(negedge clk);
        while (busy && g < 1000) begin
            @(negedge clk);
            g++;
        end
        if (busy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: busy got 1 expected 0");
        end
    endtask

    task automatic run_mb(input logic [12:0] mbn, input nb_t t, input nb_t l, input logic ta,
                          input logic la, input mb_t p, input bit stall, input bit pulse_start,
                          input int abort_at);
        int k, guard;
        bit acc;
        exp_t e;
        wait_idle();
        @(posedge clk); #1;
        tb_top = t; tb_left = l; tb_ta = ta; tb_la = la; mbn_in = mbn; start = 1'b1;
        e = model(t, l, ta, la, p, mbn);
        @(negedge clk);
        e.done_t = stall ? 64'd0 : 64'($time) + 64'd2580;
        exp_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        tb_top = rand_nb(); tb_left = rand_nb();
        tb_ta = 1'($urandom); tb_la = 1'($urandom); mbn_in = 13'($urandom);
        k = 0; guard = 0;
        while (k < 256 && guard < 3000) begin
            pix = p[k];
            pix_valid = stall ? ((guard % 2) == 0) : 1'b1;
            if (pulse_start && k == 50) begin
                start = 1'b1;
                mbn_in = 13'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            acc = pix_valid && pix_ready;
            @(posedge clk); #1;
            if (acc) k++;
            guard++;
            if (abort_at >= 0 && k == abort_at) break;
        end
        pix_valid = 1'b0;
        start = 1'b0;
        if (guard >= 3000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL beat_timeout: beats got %0d expected 256", k);
        end
        if (abort_at >= 0) begin
            rst_n = 1'b0;
            #1;
            check_reset("midreset");
            void'(exp_q.pop_back());
            #1;
            rst_n = 1'b1;
        end
    endtask

    // Monitor: pops the oldest expectation on each done pulse
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            check("done_single_cycle", 64'(done_prev), 64'd0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: queue got 0 entries expected 1");
            end else begin
                e = exp_q.pop_front();
                check("sad_v",    64'(sads[0]),  64'(e.sads[0]));
                check("sad_h",    64'(sads[1]),  64'(e.sads[1]));
                check("sad_dc",   64'(sads[2]),  64'(e.sads[2]));
                check("mbnumber", 64'(mbnumber), 64'(e.mbn));
                check_arr("vres",  vres,  e.vr);
                check_arr("hres",  hres,  e.hr);
                check_arr("dcres", dcres, e.dr);
                if (e.done_t != 64'd0) check("done_time", 64'($time), e.done_t);
            end
        end
        done_prev = rst_n && done;
    end

    initial begin
        nb_t t, l;
        mb_t p;
        repeat (3) @(posedge clk);
        #1;
        check_reset("por");
        rst_n = 1'b1;

        // Flat macroblock
        for (int i = 0; i < 16; i++) begin t[i] = 8'd100; l[i] = 8'd100; end
        p = make_pix(t, l, 2, 100, 0);
        run_mb(13'd1, t, l, 1'b1, 1'b1, p, 1'b0, 1'b0, -1);

        // Vertical match
        for (int i = 0; i < 16; i++) begin t[i] = 8'(10 * i); l[i] = 8'd0; end
        p = make_pix(t, l, 0, 0, 0);
        run_mb(13'd2, t, l, 1'b1, 1'b1, p, 1'b0, 1'b0, -1);

        // No neighbours
        t = rand_nb(); l = rand_nb();
        p = make_pix(t, l, 2, 130, 0);
        run_mb(13'd3, t, l, 1'b0, 1'b0, p, 1'b0, 1'b0, -1);

        // Residue wrap
        for (int i = 0; i < 16; i++) begin t[i] = 8'd200; l[i] = 8'd200; end
        p = make_pix(t, l, 2, 0, 0);
        run_mb(13'd4, t, l, 1'b1, 1'b1, p, 1'b0, 1'b0, -1);

        // Stalls with an ignored start mid-accumulation
        t = rand_nb(); l = rand_nb();
        p = make_pix(t, l, 1, 0, 20);
        run_mb(13'h1ABC, t, l, 1'b1, 1'b1, p, 1'b1, 1'b1, -1);

        // Reset at beat 100, then a fresh macroblock
        t = rand_nb(); l = rand_nb();
        p = make_pix(t, l, 0, 0, 10);
        run_mb(13'd6, t, l, 1'b1, 1'b1, p, 1'b0, 1'b0, 100);
        t = rand_nb(); l = rand_nb();
        p = make_pix(t, l, 0, 0, 15);
        run_mb(13'd7, t, l, 1'b1, 1'b0, p, 1'b0, 1'b0, -1);

        // Randomised macroblocks
        for (int n = 0; n < 8; n++) begin
            t = rand_nb(); l = rand_nb();
            p = make_pix(t, l, n % 3, int'($urandom_range(0, 255)), int'($urandom_range(0, 30)));
            run_mb(13'($urandom), t, l, 1'($urandom), 1'($urandom), p, 1'($urandom), 1'b0, -1);
        end

        wait_idle();
        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
